boot_loader: RTL and testbench

Upstream program loader for the 8-bit accumulator CPU. It accepts a byte stream over a valid/ready handshake and writes the bytes into the CPU's 32×8 main memory starting at address 0. It holds the CPU's active-high reset line `R` asserted until the image has been written (and, optionally, checksummed). On success it releases the CPU so execution starts from address 0.

---
 rtl/boot_loader.sv | 130 +++++++++++++
 tb/tb_boot_loader.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/boot_loader.sv
// Byte-stream program loader: length-prefixed frame written into CPU memory from address 0,
// CPU held in reset until the image is in place. `BOOT_LOADER_CHECKSUM_EN adds a trailing checksum byte.
module boot_loader #(
   parameter int AW    = 5,
   parameter int DEPTH = 32
) (
   input  logic          clk,
   input  logic          R_n,
   input  logic          start,
   input  logic          in_valid,
   input  logic [7:0]    in_data,
   output logic          in_ready,
   output logic [AW-1:0] mem_addr,
   output logic [7:0]    mem_data,
   output logic          mem_write,
   output logic          cpu_R,
   output logic          done,
   output logic          err
);

   typedef enum logic [2:0] {
      S_IDLE, S_LEN, S_DATA, S_CHK, S_FLUSH, S_RUN, S_ERR
   } state_t;

   localparam logic [8:0] DEPTH_W = 9'(DEPTH);

   state_t        state, state_nxt;
   logic [AW:0]   count, count_nxt;   // one spare bit so a full-depth image ends at DEPTH, not 0
   logic [AW:0]   len,   len_nxt;
   logic [AW:0]   count_inc;
   logic [AW-1:0] addr_nxt;
   logic [7:0]    data_nxt;
   logic          write_nxt;
   logic          xfer;
   logic          len_ok;
`ifdef BOOT_LOADER_CHECKSUM_EN
   logic [7:0]    sum, sum_nxt;
`endif

   assign xfer      = in_valid && in_ready;
   assign len_ok    = (in_data != 8'd0) && ({1'b0, in_data} <= DEPTH_W);
   assign count_inc = count + {{AW{1'b0}}, 1'b1};

   // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
   always_comb begin
      state_nxt = state;
      count_nxt = count;
      len_nxt   = len;
      addr_nxt  = mem_addr;
      data_nxt  = mem_data;
      write_nxt = 1'b0;
`ifdef BOOT_LOADER_CHECKSUM_EN
      sum_nxt   = sum;
`endif
      unique case (state)
         S_IDLE, S_RUN, S_ERR: begin
            if (start) begin
               state_nxt = S_LEN;
               count_nxt = '0;
`ifdef BOOT_LOADER_CHECKSUM_EN
               sum_nxt   = 8'd0;
`endif
            end
         end
         S_LEN: begin
            if (xfer) begin
               if (len_ok) begin
                  state_nxt = S_DATA;
                  len_nxt   = in_data[AW:0];
                  count_nxt = '0;
               end else begin
                  state_nxt = S_ERR;
               end
            end
         end
         S_DATA: begin
            if (xfer) begin
               write_nxt = 1'b1;
               addr_nxt  = count[AW-1:0];
               data_nxt  = in_data;
               count_nxt = count_inc;
`ifdef BOOT_LOADER_CHECKSUM_EN
               sum_nxt   = sum + in_data;
               if (count_inc == len) state_nxt = S_CHK;
`else
               if (count_inc == len) state_nxt = S_FLUSH;
`endif
            end
         end
`ifdef BOOT_LOADER_CHECKSUM_EN
         S_CHK: begin
            if (xfer) state_nxt = (in_data == sum) ? S_RUN : S_ERR;
         end
`endif
         S_FLUSH: state_nxt = S_RUN;
         default: state_nxt = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge clk or negedge R_n) begin
      if (!R_n) begin
         state     <= S_IDLE;
         count     <= '0;
         len       <= '0;
         mem_addr  <= '0;
         mem_data  <= 8'd0;
         mem_write <= 1'b0;
`ifdef BOOT_LOADER_CHECKSUM_EN
         sum       <= 8'd0;
`endif
      end else begin
         state     <= state_nxt;
         count     <= count_nxt;
         len       <= len_nxt;
         mem_addr  <= addr_nxt;
         mem_data  <= data_nxt;
         mem_write <= write_nxt;
`ifdef BOOT_LOADER_CHECKSUM_EN
         sum       <= sum_nxt;
`endif
      end
   end

   assign in_ready = (state == S_LEN) || (state == S_DATA) || (state == S_CHK);
   assign cpu_R    = (state != S_RUN);
   assign done     = (state == S_RUN);
   assign err      = (state == S_ERR);

endmodule

// File: tb/tb_boot_loader.sv
// Self-checking bench for boot_loader: random frames checked against a frame-level model
// of the memory image and the final done/err outcome.
module tb_boot_loader;
   localparam int AW    = 5;
   localparam int DEPTH = 32;

   logic          clk = 1'b0;
   logic          R_n = 1'b0;
   logic          start = 1'b0;
   logic          in_valid = 1'b0;
   logic [7:0]    in_data = 8'd0;
   logic          in_ready;
   logic [AW-1:0] mem_addr;
   logic [7:0]    mem_data;
   logic          mem_write;
   logic          cpu_R;
   logic          done;
   logic          err;

   boot_loader #(.AW(AW), .DEPTH(DEPTH)) dut (
      .clk(clk), .R_n(R_n), .start(start), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready), .mem_addr(mem_addr), .mem_data(mem_data), .mem_write(mem_write),
      .cpu_R(cpu_R), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   // Model of the CPU memory plus a log of every write strobe seen.
   logic [7:0]    tb_mem [DEPTH];
   logic [AW-1:0] log_a [$];
   logic [7:0]    log_d [$];
   int            log_c [$];

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (mem_write === 1'b1) begin
         tb_mem[mem_addr] <= mem_data;
         log_a.push_back(mem_addr);
         log_d.push_back(mem_data);
         log_c.push_back(cyc);
      end
   end

   // Frame under test and the model's expectations for it.
   logic [7:0] frame_q [$];
   logic [7:0] exp_d [$];
   logic       exp_done;
   logic       exp_err;

   task automatic clear_log();
      log_a.delete(); log_d.delete(); log_c.delete();
   endtask

   task automatic model_frame();
      int n;
      logic [7:0] s;
      exp_d.delete();
      n = int'(frame_q[0]);
      if (n == 0 || n > DEPTH) begin
         exp_done = 1'b0; exp_err = 1'b1;
      end else begin
         s = 8'd0;
         for (int i = 1; i <= n; i++) begin
            exp_d.push_back(frame_q[i]);
            s = s + frame_q[i];
         end
`ifdef BOOT_LOADER_CHECKSUM_EN
         exp_err  = (frame_q[n+1] != s);
         exp_done = !exp_err;
`else
         exp_err  = 1'b0;
         exp_done = 1'b1;
`endif
      end
   endtask

   task automatic make_frame(input int n);
      logic [7:0] s;
      logic [7:0] b;
      frame_q.delete();
      frame_q.push_back(8'(n));
      s = 8'd0;
      for (int i = 0; i < n; i++) begin
         b = 8'($urandom_range(0, 255));
         frame_q.push_back(b);
         s = s + b;
      end
`ifdef BOOT_LOADER_CHECKSUM_EN
      frame_q.push_back(s);
`endif
   endtask

   task automatic pulse_start();
      @(negedge clk);
      in_valid = 1'b0;
      start    = 1'b1;
      @(negedge clk);
      start    = 1'b0;
      clear_log();
   endtask

   // Present one byte, optionally after idle cycles; returns just after the accepting edge.
   task automatic send_byte(input logic [7:0] b, input int gap);
      bit ok;
      repeat (gap) begin
         @(negedge clk);
         in_valid = 1'b0;
      end
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = b;
      ok = 1'b0;
      for (int k = 0; k < 50; k++) begin
         if (in_ready === 1'b1) begin
            @(posedge clk);
            ok = 1'b1;
            break;
         end
         @(posedge clk);
         @(negedge clk);
      end
      total++;
      if (!ok) begin bad++; $display("FAIL send_timeout byte=%02h in_ready never rose", b); end
   endtask

   task automatic send_frame(input int max_gap);
      foreach (frame_q[i]) send_byte(frame_q[i], (max_gap == 0) ? 0 : int'($urandom_range(0, max_gap)));
   endtask

   task automatic test_reset();
      bit same;
      for (int i = 0; i < DEPTH; i++) tb_mem[i] = 8'(8'hA5 ^ i);
      R_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      R_n = 1'b1;
      #1;
      total++; if (cpu_R !== 1'b1) begin bad++; $display("FAIL reset_cpu_R got=%b want=1", cpu_R); end
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready got=%b want=0", in_ready); end
      total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
      total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b want=0", err); end
      total++; if (mem_write !== 1'b0) begin bad++; $display("FAIL reset_mem_write got=%b want=0", mem_write); end
      total++; if (mem_addr !== '0 || mem_data !== 8'd0) begin bad++; $display("FAIL reset_mem_bus got=%0d/%02h want=0/00", mem_addr, mem_data); end
      repeat (2) @(posedge clk);
      #1;
      same = 1'b1;
      for (int i = 0; i < DEPTH; i++) if (tb_mem[i] !== 8'(8'hA5 ^ i)) same = 1'b0;
      total++; if (!same || log_a.size() != 0) begin bad++; $display("FAIL reset_mem_kept writes=%0d want=0", log_a.size()); end
   endtask

   task automatic test_nominal();
      pulse_start();
      frame_q.delete();
      frame_q.push_back(8'h03); frame_q.push_back(8'hE0); frame_q.push_back(8'h09); frame_q.push_back(8'h15);
`ifdef BOOT_LOADER_CHECKSUM_EN
      frame_q.push_back(8'hFE);
`endif
      model_frame();
      send_frame(0);
      #1;
`ifdef BOOT_LOADER_CHECKSUM_EN
      total++; if (done !== 1'b1 || cpu_R !== 1'b0) begin bad++; $display("FAIL nominal_run got done=%b cpu_R=%b want 1/0", done, cpu_R); end
      total++; if (mem_write !== 1'b0) begin bad++; $display("FAIL nominal_no_chk_write got=%b want=0", mem_write); end
`else
      total++; if (mem_write !== 1'b1 || cpu_R !== 1'b1) begin bad++; $display("FAIL nominal_last_strobe got wr=%b cpu_R=%b want 1/1", mem_write, cpu_R); end
      @(posedge clk);
      #1;
      total++; if (done !== 1'b1 || cpu_R !== 1'b0) begin bad++; $display("FAIL nominal_run got done=%b cpu_R=%b want 1/0", done, cpu_R); end
      total++; if (mem_write !== 1'b0) begin bad++; $display("FAIL nominal_strobe_end got=%b want=0", mem_write); end
`endif
      repeat (2) @(posedge clk);
      #1;
      total++; if (log_a.size() != exp_d.size()) begin bad++; $display("FAIL nominal_count got=%0d want=%0d", log_a.size(), exp_d.size()); end
      for (int i = 0; i < log_a.size() && i < exp_d.size(); i++) begin
         total++;
         if (log_a[i] !== AW'(i) || log_d[i] !== exp_d[i]) begin
            bad++; $display("FAIL nominal_write%0d got=%0d/%02h want=%0d/%02h", i, log_a[i], log_d[i], i, exp_d[i]);
         end
      end
      for (int i = 1; i < log_c.size(); i++) begin
         total++; if (log_c[i] != log_c[i-1] + 1) begin bad++; $display("FAIL nominal_b2b gap at %0d got=%0d want=1", i, log_c[i] - log_c[i-1]); end
      end
      total++; if (done !== exp_done || err !== exp_err) begin bad++; $display("FAIL nominal_outcome got=%b%b want=%b%b", done, err, exp_done, exp_err); end
   endtask

   task automatic test_bad_length();
      logic [7:0] lens [2];
      int n;
      lens[0] = 8'h00; lens[1] = 8'h21;
      for (int t = 0; t < 2; t++) begin
         pulse_start();
         frame_q.delete();
         frame_q.push_back(lens[t]);
         model_frame();
         send_byte(lens[t], 0);
         #1;
         total++; if (err !== exp_err || in_ready !== 1'b0) begin bad++; $display("FAIL badlen_%02h got err=%b rdy=%b want %b/0", lens[t], err, in_ready, exp_err); end
         total++; if (cpu_R !== 1'b1) begin bad++; $display("FAIL badlen_%02h_cpu_R got=%b want=1", lens[t], cpu_R); end
         repeat (3) @(posedge clk);
         #1;
         total++; if (log_a.size() != 0) begin bad++; $display("FAIL badlen_%02h_writes got=%0d want=0", lens[t], log_a.size()); end
      end
      pulse_start();
      n = int'($urandom_range(1, 8));
      make_frame(n);
      model_frame();
      send_frame(1);
      repeat (3) @(posedge clk);
      #1;
      total++; if (done !== 1'b1 || err !== 1'b0) begin bad++; $display("FAIL badlen_recover got done=%b err=%b want 1/0", done, err); end
      total++; if (log_a.size() != n) begin bad++; $display("FAIL badlen_recover_count got=%0d want=%0d", log_a.size(), n); end
   endtask

`ifdef BOOT_LOADER_CHECKSUM_EN
   task automatic test_checksum_mismatch();
      pulse_start();
      frame_q.delete();
      frame_q.push_back(8'h02); frame_q.push_back(8'h01); frame_q.push_back(8'h02); frame_q.push_back(8'h04);
      model_frame();
      send_frame(0);
      repeat (3) @(posedge clk);
      #1;
      total++; if (err !== exp_err || done !== exp_done) begin bad++; $display("FAIL chk_outcome got err=%b done=%b want %b/%b", err, done, exp_err, exp_done); end
      total++; if (cpu_R !== 1'b1) begin bad++; $display("FAIL chk_cpu_R got=%b want=1", cpu_R); end
      total++; if (log_a.size() != 2) begin bad++; $display("FAIL chk_writes got=%0d want=2", log_a.size()); end
   endtask
`endif

   task automatic test_full_depth();
      bit ok;
      pulse_start();
      make_frame(DEPTH);
      model_frame();
      send_frame(2);
      repeat (3) @(posedge clk);
      #1;
      total++; if (log_a.size() != DEPTH) begin bad++; $display("FAIL full_count got=%0d want=%0d", log_a.size(), DEPTH); end
      ok = 1'b1;
      for (int i = 0; i < log_a.size() && i < DEPTH; i++)
         if (log_a[i] !== AW'(i) || log_d[i] !== exp_d[i]) begin
            ok = 1'b0;
            $display("FAIL full_write%0d got=%0d/%02h want=%0d/%02h", i, log_a[i], log_d[i], i, exp_d[i]);
         end
      total++; if (!ok) bad++;
      total++; if (done !== 1'b1 || cpu_R !== 1'b0) begin bad++; $display("FAIL full_run got done=%b cpu_R=%b want 1/0", done, cpu_R); end
   endtask

   task automatic test_reset_midload();
      bit ok;
      pulse_start();
      make_frame(8);
      for (int i = 0; i < 6; i++) send_byte(frame_q[i], 0);
      @(negedge clk);
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      total++; if (log_a.size() != 5) begin bad++; $display("FAIL midload_pre_writes got=%0d want=5", log_a.size()); end
      R_n = 1'b0;
      #1;
      total++; if (mem_write !== 1'b0 || in_ready !== 1'b0 || cpu_R !== 1'b1 || done !== 1'b0 || err !== 1'b0) begin
         bad++; $display("FAIL midload_reset got wr=%b rdy=%b cpu_R=%b done=%b err=%b want 0/0/1/0/0", mem_write, in_ready, cpu_R, done, err);
      end
      clear_log();
      repeat (3) @(posedge clk);
      #1;
      total++; if (log_a.size() != 0) begin bad++; $display("FAIL midload_spurious got=%0d want=0", log_a.size()); end
      @(negedge clk);
      R_n = 1'b1;
      pulse_start();
      make_frame(6);
      model_frame();
      send_frame(1);
      repeat (3) @(posedge clk);
      #1;
      ok = 1'b1;
      for (int i = 0; i < 6; i++) if (tb_mem[i] !== exp_d[i]) ok = 1'b0;
      total++; if (!ok) begin bad++; $display("FAIL midload_overwrite mem0=%02h want=%02h", tb_mem[0], exp_d[0]); end
      total++; if (done !== 1'b1) begin bad++; $display("FAIL midload_done got=%b want=1", done); end
   endtask

   initial begin
      test_reset();
      test_nominal();
      test_bad_length();
`ifdef BOOT_LOADER_CHECKSUM_EN
      test_checksum_mismatch();
`endif
      test_full_depth();
      test_reset_midload();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1, "watchdog");
   end

endmodule
